// File: rtl/nes_bus_pkg.sv
// Shared NES bus definitions: SPR DMA state encoding and register addresses used by the
// bus, APU and DMA blocks.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StAlign1 = 3'd1,
    StAlign2 = 3'd2,
    StRead   = 3'd3,
    StWrite  = 3'd4
  } spr_state_e;

  localparam logic [15:0] DmaTrigAddr   = 16'h4014;
  localparam logic [15:0] OamDataAddr   = 16'h2004;
  localparam logic [15:0] ApuStatusAddr = 16'h4015;

endpackage

// File: rtl/nes_spr_dma.sv
// Sprite (OAM) DMA: on a CPU write to $4014 copies page {page, 00..FF} into OAM via $2004,
// holding the bus request for the whole transfer and stalling on DMC cycle theft.
module nes_spr_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_TRIG_ADDR = DmaTrigAddr,
  parameter logic [15:0] OAM_DATA_ADDR = OamDataAddr
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [15:0] i_cpu_addr,
  input  logic        i_cpu_r_wn,
  input  logic [7:0]  i_cpu_wdata,
  input  logic        i_cpu_pause,
  output logic        o_spr_req,
  input  logic        i_spr_gnt,
  output logic [15:0] o_spr_addr,
  output logic        o_spr_wn,
  output logic [7:0]  o_spr_wdata,
  input  logic [7:0]  i_spr_rdata,
  output logic        o_busy
);

  spr_state_e state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] buf_q, buf_d;
  logic       two_align_q, two_align_d;
  logic       r_odd;
  logic       trig;

  assign trig = (state_q == StIdle) && (i_cpu_addr == DMA_TRIG_ADDR) && !i_cpu_r_wn &&
                !i_cpu_pause;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= StIdle;
      page_q      <= 8'h00;
      idx_q       <= 8'h00;
      buf_q       <= 8'h00;
      two_align_q <= 1'b0;
      r_odd       <= 1'b0;
    end else begin
      state_q     <= state_d;
      page_q      <= page_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      two_align_q <= two_align_d;
      r_odd       <= ~r_odd;
    end
  end

  // Bus outputs decode only registered state, so they never combinationally follow inputs.
  always_comb begin
    state_d     = state_q;
    page_d      = page_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    two_align_d = two_align_q;
    o_spr_req   = 1'b0;
    o_spr_addr  = 16'h0000;
    o_spr_wn    = 1'b1;
    o_spr_wdata = 8'h00;
    unique case (state_q)
      StIdle: begin
        if (trig) begin
          state_d     = StAlign1;
          page_d      = i_cpu_wdata;
          idx_d       = 8'h00;
          two_align_d = r_odd;
        end
      end
      StAlign1: begin
        o_spr_req  = 1'b1;
        o_spr_addr = DMA_TRIG_ADDR;
        state_d    = two_align_q ? StAlign2 : StRead;
      end
      StAlign2: begin
        o_spr_req  = 1'b1;
        o_spr_addr = DMA_TRIG_ADDR;
        state_d    = StRead;
      end
      StRead: begin
        o_spr_req  = 1'b1;
        o_spr_addr = {page_q, idx_q};
        if (i_spr_gnt) begin
          buf_d   = i_spr_rdata;
          state_d = StWrite;
        end
      end
      StWrite: begin
        o_spr_req   = 1'b1;
        o_spr_wn    = 1'b0;
        o_spr_addr  = OAM_DATA_ADDR;
        o_spr_wdata = buf_q;
        if (i_spr_gnt) begin
          if (idx_q == 8'hFF) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = StRead;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_busy = (state_q != StIdle);

endmodule

// File: tb/tb_nes_spr_dma.sv
// Directed bench for nes_spr_dma: memory model byte[a] = a[7:0] ^ 8'hA5, DMC theft via gnt.
module tb_nes_spr_dma;

  logic        clk;
  logic        rstn;
  logic [15:0] cpu_addr;
  logic        cpu_r_wn;
  logic [7:0]  cpu_wdata;
  logic        cpu_pause;
  logic        spr_req;
  logic        spr_gnt;
  logic [15:0] spr_addr;
  logic        spr_wn;
  logic [7:0]  spr_wdata;
  logic [7:0]  spr_rdata;
  logic        busy;

  int unsigned tests_run;
  int unsigned tests_failed;
  int unsigned cyc;

  int          req_cnt;
  logic [7:0]  wr_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] first_addr;
  logic        first_wn;
  logic        first_busy;
  int          wr_stall_bad;
  int          wr_stall_seen;
  int          wr_addr_bad;
  bit          timed_out;

  nes_spr_dma dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_r_wn  (cpu_r_wn),
    .i_cpu_wdata (cpu_wdata),
    .i_cpu_pause (cpu_pause),
    .o_spr_req   (spr_req),
    .i_spr_gnt   (spr_gnt),
    .o_spr_addr  (spr_addr),
    .o_spr_wn    (spr_wn),
    .o_spr_wdata (spr_wdata),
    .i_spr_rdata (spr_rdata),
    .o_busy      (busy)
  );

  assign spr_rdata = spr_addr[7:0] ^ 8'hA5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mirrors the parity bit: cleared by reset, toggles every cycle afterwards.
  always @(posedge clk) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Triggers a transfer at the requested parity and services it cycle by cycle; idx values
  // of -1 disable the corresponding stall or abort.
  task automatic run_xfer(input logic [7:0] page, input bit want_odd, input int rd_stall_idx,
                          input int rd_stall_n, input int wr_stall_idx, input int wr_stall_n,
                          input int abort_idx);
    int rd_left;
    int wr_left;
    int cur_idx;
    rd_left = rd_stall_n;
    wr_left = wr_stall_n;
    cur_idx = -1;
    wr_q.delete();
    rd_q.delete();
    req_cnt = 0;
    wr_stall_bad = 0;
    wr_stall_seen = 0;
    wr_addr_bad = 0;
    timed_out = 1'b0;
    spr_gnt = 1'b1;
    @(posedge clk); #1;
    if (cyc[0] != want_odd) begin
      @(posedge clk); #1;
    end
    cpu_addr = 16'h4014;
    cpu_r_wn = 1'b0;
    cpu_wdata = page;
    @(posedge clk); #1;
    cpu_addr = 16'h0000;
    cpu_r_wn = 1'b1;
    cpu_wdata = 8'h00;
    first_addr = spr_addr;
    first_wn = spr_wn;
    first_busy = busy;
    for (int c = 0; c < 1200; c++) begin
      if (!spr_req) break;
      req_cnt++;
      spr_gnt = 1'b1;
      if (spr_wn && spr_addr[15:8] == page) begin
        cur_idx = int'(spr_addr[7:0]);
        if (cur_idx == abort_idx) begin
          rstn = 1'b0;
          @(posedge clk); #1;
          rstn = 1'b1;
          return;
        end
        if (cur_idx == rd_stall_idx && rd_left > 0) begin
          spr_gnt = 1'b0;
          rd_left--;
        end else begin
          rd_q.push_back(spr_addr);
        end
      end else if (!spr_wn) begin
        if (spr_addr !== 16'h2004) wr_addr_bad++;
        if (cur_idx == wr_stall_idx && wr_left > 0) begin
          spr_gnt = 1'b0;
          wr_left--;
          wr_stall_seen++;
          if (spr_wdata !== (8'(cur_idx) ^ 8'hA5)) wr_stall_bad++;
        end else begin
          wr_q.push_back(spr_wdata);
        end
      end
      @(posedge clk); #1;
    end
    spr_gnt = 1'b1;
    if (spr_req) timed_out = 1'b1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cpu_addr = 16'h4014;
    cpu_r_wn = 1'b0;
    cpu_wdata = 8'h05;
    @(posedge clk); #1;
    cpu_addr = 16'h0000;
    cpu_r_wn = 1'b1;
    tests_run++;
    if (spr_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_req: got %b, required 0", spr_req);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy: got %b, required 0", busy);
    end
    tests_run++;
    if (spr_addr !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_addr: got %h, required 0000", spr_addr);
    end
    tests_run++;
    if (spr_wn !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_wn: got %b, required 1", spr_wn);
    end
    tests_run++;
    if (spr_wdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_wdata: got %h, required 00", spr_wdata);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || spr_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_beats_trigger: busy %b req %b, required 0 0", busy, spr_req);
    end
  endtask

  task automatic test_even;
    int bad;
    run_xfer(8'h02, 1'b0, -1, 0, -1, 0, -1);
    tests_run++;
    if (timed_out) begin
      tests_failed++;
      $display("FAIL even_timeout: req still %b after 1200 cycles, required 0", spr_req);
    end
    tests_run++;
    if (first_busy !== 1'b1 || first_addr !== 16'h4014 || first_wn !== 1'b1) begin
      tests_failed++;
      $display("FAIL even_align: busy %b addr %h wn %b, required 1 4014 1",
               first_busy, first_addr, first_wn);
    end
    tests_run++;
    if (req_cnt != 513) begin
      tests_failed++;
      $display("FAIL even_req_len: got %0d, required 513", req_cnt);
    end
    tests_run++;
    if (wr_addr_bad != 0) begin
      tests_failed++;
      $display("FAIL even_wr_addr: %0d writes off $2004, required 0", wr_addr_bad);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (i >= wr_q.size() || wr_q[i] !== (8'(i) ^ 8'hA5)) bad++;
    end
    tests_run++;
    if (wr_q.size() != 256 || bad != 0) begin
      tests_failed++;
      $display("FAIL even_data: %0d bytes %0d wrong, required 256 bytes 0 wrong",
               wr_q.size(), bad);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (i >= rd_q.size() || rd_q[i] !== (16'h0200 | 16'(i))) bad++;
    end
    tests_run++;
    if (rd_q.size() != 256 || bad != 0) begin
      tests_failed++;
      $display("FAIL even_reads: %0d reads %0d wrong, required 256 reads 0 wrong",
               rd_q.size(), bad);
    end
    tests_run++;
    if (busy !== 1'b0 || spr_addr !== 16'h0000) begin
      tests_failed++;
      $display("FAIL even_end_idle: busy %b addr %h, required 0 0000", busy, spr_addr);
    end
  endtask

  task automatic test_odd;
    int bad;
    run_xfer(8'h02, 1'b1, -1, 0, -1, 0, -1);
    tests_run++;
    if (req_cnt != 514) begin
      tests_failed++;
      $display("FAIL odd_req_len: got %0d, required 514", req_cnt);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (i >= wr_q.size() || wr_q[i] !== (8'(i) ^ 8'hA5)) bad++;
    end
    tests_run++;
    if (wr_q.size() != 256 || bad != 0) begin
      tests_failed++;
      $display("FAIL odd_data: %0d bytes %0d wrong, required 256 bytes 0 wrong",
               wr_q.size(), bad);
    end
  endtask

  task automatic test_read_stall;
    int bad;
    run_xfer(8'h02, 1'b0, 16, 4, -1, 0, -1);
    tests_run++;
    if (req_cnt != 517) begin
      tests_failed++;
      $display("FAIL rd_stall_len: got %0d, required 517", req_cnt);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (i >= wr_q.size() || wr_q[i] !== (8'(i) ^ 8'hA5)) bad++;
      if (i >= rd_q.size() || rd_q[i] !== (16'h0200 | 16'(i))) bad++;
    end
    tests_run++;
    if (wr_q.size() != 256 || rd_q.size() != 256 || bad != 0) begin
      tests_failed++;
      $display("FAIL rd_stall_data: %0d writes %0d reads %0d wrong, required 256 256 0",
               wr_q.size(), rd_q.size(), bad);
    end
  endtask

  task automatic test_write_stall;
    int bad;
    run_xfer(8'h02, 1'b0, -1, 0, 127, 3, -1);
    tests_run++;
    if (req_cnt != 516) begin
      tests_failed++;
      $display("FAIL wr_stall_len: got %0d, required 516", req_cnt);
    end
    tests_run++;
    if (wr_stall_seen != 3 || wr_stall_bad != 0) begin
      tests_failed++;
      $display("FAIL wr_stall_hold: %0d held writes %0d wrong, required 3 0",
               wr_stall_seen, wr_stall_bad);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (i >= wr_q.size() || wr_q[i] !== (8'(i) ^ 8'hA5)) bad++;
    end
    tests_run++;
    if (wr_q.size() != 256 || bad != 0 || wr_addr_bad != 0) begin
      tests_failed++;
      $display("FAIL wr_stall_data: %0d bytes %0d wrong %0d bad addr, required 256 0 0",
               wr_q.size(), bad, wr_addr_bad);
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    run_xfer(8'h02, 1'b0, -1, 0, -1, 0, 128);
    tests_run++;
    if (spr_req !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: req %b busy %b, required 0 0", spr_req, busy);
    end
    run_xfer(8'h03, 1'b0, -1, 0, -1, 0, -1);
    tests_run++;
    if (rd_q.size() == 0 || rd_q[0] !== 16'h0300) begin
      tests_failed++;
      $display("FAIL restart_first_read: got %h (%0d reads), required 0300",
               (rd_q.size() == 0) ? 16'hxxxx : rd_q[0], rd_q.size());
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (i >= wr_q.size() || wr_q[i] !== (8'(i) ^ 8'hA5)) bad++;
    end
    tests_run++;
    if (req_cnt != 513 || wr_q.size() != 256 || bad != 0) begin
      tests_failed++;
      $display("FAIL restart_xfer: req %0d bytes %0d wrong %0d, required 513 256 0",
               req_cnt, wr_q.size(), bad);
    end
  endtask

  task automatic test_no_trigger;
    logic [15:0] v_addr[3];
    logic        v_rwn[3];
    logic        v_pause[3];
    v_addr  = '{16'h4014, 16'h4015, 16'h4014};
    v_rwn   = '{1'b1, 1'b0, 1'b0};
    v_pause = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      cpu_addr = v_addr[k];
      cpu_r_wn = v_rwn[k];
      cpu_pause = v_pause[k];
      cpu_wdata = 8'h04;
      @(posedge clk); #1;
      cpu_addr = 16'h0000;
      cpu_r_wn = 1'b1;
      cpu_pause = 1'b0;
      for (int c = 0; c < 2; c++) begin
        tests_run++;
        if (spr_req !== 1'b0 || busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL no_trigger_%0d: req %b busy %b, required 0 0", k, spr_req, busy);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rstn = 1'b0;
    cpu_addr = 16'h0000;
    cpu_r_wn = 1'b1;
    cpu_wdata = 8'h00;
    cpu_pause = 1'b0;
    spr_gnt = 1'b1;
    test_reset();
    test_even();
    test_odd();
    test_read_stall();
    test_write_stall();
    test_reset_mid();
    test_no_trigger();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
